// File: rtl/picoaes_stream_ctrl.sv
// rtl/picoaes_stream_ctrl.sv - stream front-end that sequences picoaes register accesses
//
// Purpose: accepts {key, plaintext} blocks on a valid/ready stream, writes them into the
// picoaes register peripheral, strobes CTRL, polls STATUS and reads the ciphertext back,
// then presents it (or a poll-timeout error) on a valid/ready result stream.
//
// Ports:
//   clk, resetn             clock and synchronous active-low reset
//   s_valid/s_ready         input block handshake, s_key/s_pt ([127:96] is word 0)
//   m_valid/m_ready         result handshake, m_ct ([127:96] from CTW0), m_err (poll timeout)
//   busy                    high whenever the sequencer is not idle
//   aes_valid/aes_ready     picoaes bus handshake, aes_wen (1 write), aes_addr, aes_wdata
//   aes_rdata               read data, sampled in the handshake cycle
//
// Option macro: PICOAES_KEY_CACHE_EN keeps the last fully written key and skips the key
// writes when the next block carries the same key.

module picoaes_stream_ctrl #(
  parameter int POLL_MAX = 1024,
  parameter int ADDR_W   = 24
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [127:0]      s_key,
  input  logic [127:0]      s_pt,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [127:0]      m_ct,
  output logic              m_err,
  output logic              busy,
  output logic              aes_valid,
  output logic              aes_wen,
  output logic [ADDR_W-1:0] aes_addr,
  output logic [31:0]       aes_wdata,
  input  logic [31:0]       aes_rdata,
  input  logic              aes_ready
);

  localparam int CNT_W = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WKEY, S_WPT, S_CTRL, S_POLL, S_RDCT, S_OUT
  } state_t;

  state_t           state, state_d;
  logic [1:0]       idx, idx_d;
  logic [127:0]     key_q, pt_q, ct_q;
  logic             err_q;
  logic [CNT_W-1:0] poll_cnt;
  logic             rdy_q;
  logic [7:0]       addr8;
  logic             accept, key_done, poll_clr, poll_inc, timeout, ct_load, out_done;
  logic             key_hit;

`ifdef PICOAES_KEY_CACHE_EN
  logic [127:0] key_cache;
  logic         key_valid;
  assign key_hit = key_valid && (s_key == key_cache);
`else
  assign key_hit = 1'b0;
`endif

  assign aes_addr = ADDR_W'(addr8);
  assign m_ct     = ct_q;
  assign m_err    = err_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      idx   <= 2'd0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  // Word idx k of a 128-bit block is bits [32k+31:32k], i.e. register word 3-k,
  // so every phase walks the register map downwards from word 3 to word 0.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    busy      = (state != S_IDLE);
    aes_valid = 1'b0;
    aes_wen   = 1'b0;
    addr8     = 8'h00;
    aes_wdata = 32'h0;
    accept    = 1'b0;
    key_done  = 1'b0;
    poll_clr  = 1'b0;
    poll_inc  = 1'b0;
    timeout   = 1'b0;
    ct_load   = 1'b0;
    out_done  = 1'b0;
    case (state)
      S_IDLE: begin
        s_ready = rdy_q;
        if (s_valid && rdy_q) begin
          accept  = 1'b1;
          idx_d   = 2'd0;
          state_d = key_hit ? S_WPT : S_WKEY;
        end
      end
      S_WKEY: begin
        aes_valid = 1'b1;
        aes_wen   = 1'b1;
        addr8     = 8'h10 - {4'd0, idx, 2'd0};
        aes_wdata = key_q[{idx, 5'd0} +: 32];
        if (aes_ready) begin
          idx_d = idx + 2'd1;
          if (idx == 2'd3) begin
            state_d  = S_WPT;
            key_done = 1'b1;
          end
        end
      end
      S_WPT: begin
        aes_valid = 1'b1;
        aes_wen   = 1'b1;
        addr8     = 8'h20 - {4'd0, idx, 2'd0};
        aes_wdata = pt_q[{idx, 5'd0} +: 32];
        if (aes_ready) begin
          idx_d = idx + 2'd1;
          if (idx == 2'd3) state_d = S_CTRL;
        end
      end
      S_CTRL: begin
        aes_valid = 1'b1;
        aes_wen   = 1'b1;
        addr8     = 8'h00;
        aes_wdata = idx[1] ? 32'h4 : 32'h6;
        if (aes_ready) begin
          idx_d = idx + 2'd1;
          if (idx == 2'd3) begin
            state_d  = S_POLL;
            poll_clr = 1'b1;
          end
        end
      end
      S_POLL: begin
        aes_valid = 1'b1;
        addr8     = 8'h44;
        if (aes_ready) begin
          if (aes_rdata[0]) begin
            state_d = S_RDCT;
            idx_d   = 2'd0;
          end else if (poll_cnt >= POLL_LAST) begin
            state_d = S_OUT;
            timeout = 1'b1;
          end else begin
            poll_inc = 1'b1;
          end
        end
      end
      S_RDCT: begin
        aes_valid = 1'b1;
        addr8     = 8'h40 - {4'd0, idx, 2'd0};
        if (aes_ready) begin
          ct_load = 1'b1;
          idx_d   = idx + 2'd1;
          if (idx == 2'd3) state_d = S_OUT;
        end
      end
      S_OUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          state_d  = S_IDLE;
          out_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // rdy_q holds s_ready low for the first idle cycle after reset or after a result
  // is taken, so a new block is never accepted in the cycle m_valid falls.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      key_q    <= '0;
      pt_q     <= '0;
      ct_q     <= '0;
      err_q    <= 1'b0;
      poll_cnt <= '0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= (state == S_IDLE);
      if (accept) begin
        key_q <= s_key;
        pt_q  <= s_pt;
        ct_q  <= '0;
        err_q <= 1'b0;
      end
      if (poll_clr)      poll_cnt <= '0;
      else if (poll_inc) poll_cnt <= poll_cnt + CNT_W'(1);
      if (ct_load)  ct_q[{idx, 5'd0} +: 32] <= aes_rdata;
      if (timeout)  err_q <= 1'b1;
      if (out_done) err_q <= 1'b0;
    end
  end

`ifdef PICOAES_KEY_CACHE_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      key_cache <= '0;
      key_valid <= 1'b0;
    end else begin
      if (key_done) begin
        key_cache <= key_q;
        key_valid <= 1'b1;
      end
      if (timeout) key_valid <= 1'b0;
    end
  end
`endif

endmodule
